// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous
// instruction memory (slave). Read data is returned the cycle after imem_en.
interface if_fetch_if #(
  parameter int unsigned IMEM_AW = 10
);
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction memory and
// presents one instruction per cycle, with stall hold, redirect kill and halt/resume.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  input  logic        Halt,
  input  logic        Go,
  if_fetch_if.master  imem,
  output logic [31:0] PC_out,
  output logic [31:0] PC4_out,
  output logic [31:0] IR_out,
  output logic        Effective_out,
  output logic        Halted
);

  typedef enum logic [0:0] {StFetch, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic        issue;

  always_comb begin
    state_d      = state_q;
    f_pc_d       = f_pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    hold_valid_d = hold_valid_q;
    hold_ir_d    = hold_ir_q;
    issue        = 1'b0;
    if (rst) begin
      state_d      = StFetch;
      f_pc_d       = RESET_PC;
      resp_valid_d = 1'b0;
      resp_pc_d    = 32'h0;
      hold_valid_d = 1'b0;
      hold_ir_d    = 32'h0;
    end else if (Redirect) begin
      // Kill the wrong-path response; state (including HALTED) is kept.
      f_pc_d       = Redirect_PC & ~32'd3;
      resp_valid_d = 1'b0;
      hold_valid_d = 1'b0;
    end else if (state_q == StHalted) begin
      if (Go && !Halt) state_d = StFetch;
    end else if (Halt) begin
      state_d      = StHalted;
      resp_valid_d = 1'b0;
      hold_valid_d = 1'b0;
    end else if (Stall) begin
      // Memory data is only guaranteed in the first stalled cycle; keep it.
      if (resp_valid_q && !hold_valid_q) begin
        hold_ir_d    = imem.imem_data;
        hold_valid_d = 1'b1;
      end
    end else begin
      issue        = 1'b1;
      resp_pc_d    = f_pc_q;
      resp_valid_d = 1'b1;
      hold_valid_d = 1'b0;
      f_pc_d       = f_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    f_pc_q       <= f_pc_d;
    resp_valid_q <= resp_valid_d;
    resp_pc_q    <= resp_pc_d;
    hold_valid_q <= hold_valid_d;
    hold_ir_q    <= hold_ir_d;
  end

  assign imem.imem_en   = issue;
  assign imem.imem_addr = f_pc_q[IMEM_AW+1:2];

  always_comb begin
    PC_out        = 32'h0;
    PC4_out       = 32'h0;
    IR_out        = 32'h0;
    Effective_out = 1'b0;
    if (resp_valid_q) begin
      PC_out        = resp_pc_q;
      PC4_out       = resp_pc_q + 32'd4;
      IR_out        = hold_valid_q ? hold_ir_q : imem.imem_data;
      Effective_out = 1'b1;
    end
  end

  assign Halted = (state_q == StHalted);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by random control traffic, all
// checked against an architectural model that looks instructions up in the memory image.
module tb_if_fetch;
  localparam int unsigned AW   = 10;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam int unsigned NMEM = 1 << AW;

  logic        clk = 1'b0;
  logic        rst, Stall, Redirect, Halt, Go;
  logic [31:0] Redirect_PC;
  logic [31:0] PC_out, PC4_out, IR_out;
  logic        Effective_out, Halted;

  if_fetch_if #(.IMEM_AW(AW)) imem_bus ();

  if_fetch #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .Stall         (Stall),
    .Redirect      (Redirect),
    .Redirect_PC   (Redirect_PC),
    .Halt          (Halt),
    .Go            (Go),
    .imem          (imem_bus.master),
    .PC_out        (PC_out),
    .PC4_out       (PC4_out),
    .IR_out        (IR_out),
    .Effective_out (Effective_out),
    .Halted        (Halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory; output is garbage unless read the previous cycle.
  logic [31:0] mem [NMEM];
  initial for (int k = 0; k < NMEM; k++) mem[k] = 32'h1000_0000 + k;
  always @(posedge clk) begin
    if (imem_bus.imem_en) imem_bus.imem_data <= mem[imem_bus.imem_addr];
    else                  imem_bus.imem_data <= $urandom;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural model: what is presented, where fetch continues, halted or not.
  logic        m_valid, m_halted;
  logic [31:0] m_pc, m_fpc;

  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    logic [AW-1:0] w;
    w = pc[AW+1:2];
    return mem[w];
  endfunction

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                      input logic h, input logic g);
    logic        exp_en;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    rst = r; Stall = s; Redirect = rd; Redirect_PC = rp; Halt = h; Go = g;
    #1;
    exp_en   = !r && !rd && !m_halted && !h && !s;
    exp_addr = m_fpc[AW+1:2];
    check("effective", 32'(Effective_out), 32'(m_valid));
    check("pc_out", PC_out, m_valid ? m_pc : 32'h0);
    check("pc4_out", PC4_out, m_valid ? m_pc + 32'd4 : 32'h0);
    check("ir_out", IR_out, m_valid ? mem_at(m_pc) : 32'h0);
    check("imem_en", 32'(imem_bus.imem_en), 32'(exp_en));
    if (exp_en) check("imem_addr", 32'(imem_bus.imem_addr), 32'(exp_addr));
    check("halted", 32'(Halted), 32'(m_halted));
    if (r) begin
      m_halted = 1'b0; m_fpc = RPC; m_valid = 1'b0;
    end else if (rd) begin
      m_fpc = rp & ~32'd3; m_valid = 1'b0;
    end else if (m_halted) begin
      if (g && !h) m_halted = 1'b0;
    end else if (h) begin
      m_halted = 1'b1; m_valid = 1'b0;
    end else if (!s) begin
      m_valid = 1'b1; m_pc = m_fpc; m_fpc = m_fpc + 32'd4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 32'h0; Halt = 1'b0; Go = 1'b0;
    repeat (2) @(posedge clk);
    m_halted = 1'b0; m_fpc = RPC; m_valid = 1'b0; m_pc = 32'h0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Bubble, then PC 0, 4; stall 3 cycles at PC 8; PC 12; redirect at PC 16.
    run(4);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    run(1);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    run(2);
    // Redirect with stall; land on PC 24 and halt there for 5 cycles.
    step(1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 1'b0);
    run(1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run(5);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    run(3);
    // Halt, Halt+Go stays halted, redirect while halted, then resume.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    run(2);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    run(3);
    // Wrap at the top of the address space, and low-bit masking.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run(3);
    step(1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 1'b0);
    run(3);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0, $urandom_range(99) < 30, $urandom_range(99) < 6,
           $urandom, $urandom_range(99) < 4, $urandom_range(99) < 25);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
